// File: rtl/data_cache_controller.sv
// Two-way set-associative write-through read cache between MEM stage and SRAM controller.
// Cache arrays are built only when DATA_CACHE_EN is defined; otherwise a pure handshake adapter.
module data_cache_controller #(
  parameter int unsigned SET_LOG2 = 6,
  parameter int unsigned TAG_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;

  state_t      state_q, state_d;
  logic        rd_req, wr_req;
  logic        hit;
  logic [31:0] hit_data;

  // A simultaneous read and write is serviced as a read only.
  assign rd_req       = mem_r_en;
  assign wr_req       = mem_w_en & ~mem_r_en;
  assign sram_address = address;
  assign sram_wdata   = wdata;

`ifdef DATA_CACHE_EN
  localparam int unsigned SETS = 1 << SET_LOG2;

  logic [SET_LOG2-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic [SETS-1:0]     valid0_q, valid0_d, valid1_q, valid1_d, lru_q, lru_d;
  logic [TAG_W-1:0]    tag0_q [SETS];
  logic [TAG_W-1:0]    tag1_q [SETS];
  logic [31:0]         data0_q [SETS];
  logic [31:0]         data1_q [SETS];
  logic                hit0, hit1, hit_way, victim;
  logic                fill_en, touch_en, wr_hit_en;

  assign idx      = address[SET_LOG2+1:2];
  assign tag      = address[SET_LOG2+TAG_W+1:SET_LOG2+2];
  assign hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_data = hit0 ? data0_q[idx] : data1_q[idx];
  assign victim   = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

  always_comb begin
    fill_en   = (state_q == READ_WAIT) && sram_ready;
    touch_en  = (state_q == IDLE) && hit && (rd_req || wr_req);
    wr_hit_en = (state_q == IDLE) && hit && wr_req;
    valid0_d  = valid0_q;
    valid1_d  = valid1_q;
    lru_d     = lru_q;
    if (fill_en) begin
      if (victim) valid1_d[idx] = 1'b1;
      else        valid0_d[idx] = 1'b1;
      lru_d[idx] = ~victim;
    end else if (touch_en) begin
      lru_d[idx] = ~hit_way;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      lru_q    <= lru_d;
    end
  end

  // Tag/data payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (fill_en && !rst) begin
      if (victim) begin
        tag1_q[idx]  <= tag;
        data1_q[idx] <= sram_rdata;
      end else begin
        tag0_q[idx]  <= tag;
        data0_q[idx] <= sram_rdata;
      end
    end else if (wr_hit_en && !rst) begin
      if (hit_way) data1_q[idx] <= wdata;
      else         data0_q[idx] <= wdata;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_req && !hit) state_d = READ_WAIT;
        else if (wr_req)    state_d = WRITE_WAIT;
      end
      READ_WAIT:  if (sram_ready) state_d = IDLE;
      WRITE_WAIT: if (sram_ready) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b1;
    rdata     = '0;
    sram_r_en = 1'b0;
    sram_w_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (hit) begin
            rdata = hit_data;
          end else begin
            sram_r_en = 1'b1;
            ready     = 1'b0;
          end
        end else if (wr_req) begin
          sram_w_en = 1'b1;
          ready     = 1'b0;
        end
      end
      READ_WAIT: begin
        ready = sram_ready;
        if (sram_ready) rdata = sram_rdata;
      end
      WRITE_WAIT: ready = sram_ready;
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Randomized bench for data_cache_controller with an LRU-list cache model and a
// five-cycle SRAM controller responder; follows DATA_CACHE_EN like the design.
module tb_data_cache_controller;

  logic        clk, rst, tb_init;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata, rdata;
  logic        ready, sram_r_en, sram_w_en;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
  logic        sram_ready;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DATA_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  data_cache_controller #(.SET_LOG2(6), .TAG_W(10)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_address(sram_address),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] key_of(input logic [31:0] a);
    return {a[20], a[11:2]};
  endfunction

  function automatic logic [31:0] init_word(input logic [10:0] k);
    if (k == 11'h100) return 32'hDEAD_BEEF;
    return ({21'b0, k} * 32'h9E37_79B1) + 32'h0013_5700;
  endfunction

  // SRAM controller responder: START, WAIT1-3 busy, END ready with data.
  logic [2:0]    cnt;
  logic [10:0]   rkey;
  logic [31:0]   sram_mem [2048];
  logic [2047:0] sram_wr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      rkey <= '0;
    end else if (cnt == 0 && (sram_r_en || sram_w_en)) begin
      cnt  <= 3'd5;
      rkey <= key_of(sram_address);
    end else if (cnt != 0) begin
      cnt <= cnt - 3'd1;
    end
  end

  always @(posedge clk) begin
    if (tb_init) sram_wr <= '0;
    else if (!rst && cnt == 0 && sram_w_en && !sram_r_en) begin
      sram_wr[key_of(sram_address)]  <= 1'b1;
      sram_mem[key_of(sram_address)] <= sram_wdata;
    end
  end

  assign sram_ready = (cnt <= 3'd1);
  assign sram_rdata = (cnt == 3'd1) ? (sram_wr[rkey] ? sram_mem[rkey] : init_word(rkey)) : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each set is a recency list, least recently used at the front.
  typedef struct packed {
    logic [9:0]  tag;
    logic [31:0] data;
  } line_t;

  line_t       lines [64][$];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] ref_rd(input logic [10:0] k);
    if (ref_mem.exists(int'(k))) return ref_mem[int'(k)];
    return init_word(k);
  endfunction

  function automatic int find(input int s, input logic [9:0] t);
    if (!CACHE_EN) return -1;
    for (int i = 0; i < lines[s].size(); i++)
      if (lines[s][i].tag == t) return i;
    return -1;
  endfunction

  task automatic use_line(input int s, input int i, input logic [31:0] d, input bit upd);
    line_t l;
    l = lines[s][i];
    if (upd) l.data = d;
    lines[s].delete(i);
    lines[s].push_back(l);
  endtask

  task automatic fill_line(input int s, input logic [9:0] t, input logic [31:0] d);
    line_t l;
    if (!CACHE_EN) return;
    l.tag  = t;
    l.data = d;
    if (lines[s].size() == 2) void'(lines[s].pop_front());
    lines[s].push_back(l);
  endtask

  task automatic clear_model();
    for (int s = 0; s < 64; s++) lines[s].delete();
  endtask

  // Entered just after a rising edge; returns just after a rising edge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit          is_wr;
    int          s, hi, stall;
    logic [9:0]  t;
    logic [10:0] k;
    bit          done, reissue;
    is_wr    = wr && !rd;
    s        = int'(a[7:2]);
    t        = a[17:8];
    k        = key_of(a);
    hi       = find(s, t);
    mem_r_en = rd;
    mem_w_en = wr;
    address  = a;
    wdata    = d;
    @(negedge clk);
    check("sram_addr", sram_address, a);
    check("sram_wdata", sram_wdata, d);
    if (!rd && !wr) begin
      check("idle_ready", {31'b0, ready}, 32'd1);
      check("idle_rdata", rdata, 32'd0);
      check("idle_en", {30'b0, sram_r_en, sram_w_en}, 32'd0);
      @(posedge clk);
    end else if (rd && hi >= 0) begin
      check("hit_ready", {31'b0, ready}, 32'd1);
      check("hit_rdata", rdata, lines[s][hi].data);
      check("hit_en", {30'b0, sram_r_en, sram_w_en}, 32'd0);
      @(posedge clk);
      use_line(s, hi, '0, 1'b0);
    end else begin
      check("issue_ready", {31'b0, ready}, 32'd0);
      check("issue_en", {30'b0, sram_r_en, sram_w_en}, {30'b0, rd, is_wr});
      stall   = 1;
      done    = 1'b0;
      reissue = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge clk);
        if (ready) done = 1'b1;
        else begin
          stall++;
          if (sram_r_en || sram_w_en) reissue = 1'b1;
        end
      end
      check("stall_cycles", stall, 5);
      check("wait_en", {31'b0, reissue}, 32'd0);
      if (rd) check("miss_rdata", rdata, ref_rd(k));
      @(posedge clk);
      if (rd) fill_line(s, t, ref_rd(k));
      else begin
        ref_mem[int'(k)] = d;
        if (hi >= 0) use_line(s, hi, d, 1'b1);
      end
    end
    #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2) | ($urandom % 4);
    if ($urandom_range(0, 7) == 0) a = a | 32'h0010_0000;
    return a;
  endfunction

  initial begin
    int op;
    rst      = 1'b1;
    tb_init  = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    address  = '0;
    wdata    = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_en", {30'b0, sram_r_en, sram_w_en}, 32'd0);
    rst     = 1'b0;
    tb_init = 1'b0;
    @(posedge clk);
    #1;

    access(1, 0, 32'h400, 0);
    access(1, 0, 32'h400, 0);
    access(0, 1, 32'h400, 32'h1234_5678);
    access(1, 0, 32'h400, 0);
    access(1, 0, 32'h500, 0);
    access(1, 0, 32'h600, 0);
    access(1, 0, 32'h500, 0);
    access(1, 0, 32'h400, 0);
    access(0, 1, 32'h800, 32'hCAFE_F00D);
    access(1, 0, 32'h800, 0);
    access(1, 1, 32'h800, 32'h5555_AAAA);
    access(1, 0, 32'h800, 0);
    access(0, 0, 32'h0, 0);

    // Reset in the middle of a read miss.
    mem_r_en = 1'b1;
    address  = 32'h204;
    @(negedge clk);
    check("abort_issue", {31'b0, sram_r_en}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_state", {30'b0, ready, sram_r_en}, 32'd1);
    mem_r_en = 1'b0;
    #1;
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_rdata", rdata, 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(1, 0, 32'h204, 0);
    access(1, 0, 32'h400, 0);

    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 19));
      if (op < 10)      access(1, 0, rand_addr(), 0);
      else if (op < 17) access(0, 1, rand_addr(), $urandom);
      else if (op < 19) access(1, 1, rand_addr(), $urandom);
      else              access(0, 0, rand_addr(), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
